// File: rtl/branch_resolve_queue_pkg.sv
// Shared types and defaults for the branch resolve queue.
// Queue entries carry the resolution packet plus the branch's own dependency mask.
package branch_resolve_queue_pkg;

  localparam int unsigned NUM_BR_FU_DEFAULT = 2;
  localparam int unsigned BRQ_DEPTH_DEFAULT = 8;
  localparam int unsigned B_MASK_W          = 4;

  typedef logic [B_MASK_W-1:0] B_MASK;

  typedef struct packed {
    logic [31:0] target;
    logic        bm_mispred;
    B_MASK       bmm;
  } BRANCH_REG_PACKET;

  typedef struct packed {
    BRANCH_REG_PACKET pkt;
    B_MASK            b_m;
  } BRQ_ENTRY;

  typedef struct packed {
    logic     valid;
    BRQ_ENTRY entry;
  } BRQ_SLOT;

  // Apply one cycle's resolution: a mispredict kills dependents, otherwise the bit retires.
  function automatic BRQ_SLOT brq_resolve(BRQ_SLOT slot, B_MASK res_bit, logic res_mis);
    BRQ_SLOT s;
    s = slot;
    if (res_mis && (|(s.entry.b_m & res_bit))) s.valid = 1'b0;
    s.entry.b_m = s.entry.b_m & ~res_bit;
    return s;
  endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Arrival and delivery signals between the complete stage, the queue and the branch stack.
interface branch_resolve_queue_if import branch_resolve_queue_pkg::*; #(
  parameter int unsigned NUM_BR_FU = NUM_BR_FU_DEFAULT,
  parameter int unsigned BRQ_DEPTH = BRQ_DEPTH_DEFAULT
);

  logic [NUM_BR_FU-1:0]           br_valid;
  BRQ_ENTRY [NUM_BR_FU-1:0]       br_in;
  BRANCH_REG_PACKET               branch_completing;
  logic                           brq_stall;
  logic [$clog2(BRQ_DEPTH+1)-1:0] brq_count;
  logic                           brq_overflow;

  modport master (
    output br_valid, br_in,
    input  branch_completing, brq_stall, brq_count, brq_overflow
  );

  modport slave (
    input  br_valid, br_in,
    output branch_completing, brq_stall, brq_count, brq_overflow
  );

endinterface

// File: rtl/branch_resolve_queue_brq_compact.sv
// Order-preserving compaction of surviving entries followed by in-order arrival append.
// Arrivals that find no free slot are dropped and flagged.
module branch_resolve_queue_brq_compact import branch_resolve_queue_pkg::*; #(
  parameter int unsigned NUM_BR_FU = NUM_BR_FU_DEFAULT,
  parameter int unsigned BRQ_DEPTH = BRQ_DEPTH_DEFAULT
) (
  input  BRQ_SLOT                        kept       [BRQ_DEPTH],
  input  BRQ_SLOT                        arrivals   [NUM_BR_FU],
  output BRQ_SLOT                        slots_next [BRQ_DEPTH],
  output logic [$clog2(BRQ_DEPTH+1)-1:0] count_next,
  output logic                           dropped
);

  localparam int unsigned CW = $clog2(BRQ_DEPTH + 1);
  localparam int unsigned IW = (BRQ_DEPTH > 1) ? $clog2(BRQ_DEPTH) : 1;

  logic [CW-1:0] fill;

  always_comb begin
    slots_next = '{default: '0};
    fill       = '0;
    dropped    = 1'b0;
    for (int i = 0; i < int'(BRQ_DEPTH); i++) begin
      if (kept[i].valid) begin
        slots_next[fill[IW-1:0]] = kept[i];
        fill = fill + CW'(1);
      end
    end
    for (int p = 0; p < int'(NUM_BR_FU); p++) begin
      if (arrivals[p].valid) begin
        if (fill < CW'(BRQ_DEPTH)) begin
          slots_next[fill[IW-1:0]] = arrivals[p];
          fill = fill + CW'(1);
        end else begin
          dropped = 1'b1;
        end
      end
    end
    count_next = fill;
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: buffers branch unit results and delivers one per cycle to the branch stack.
// Define BRQ_MISPRED_PRIORITY_EN to emit the oldest queued mispredict ahead of correct resolutions.
module branch_resolve_queue import branch_resolve_queue_pkg::*; #(
  parameter int unsigned NUM_BR_FU = NUM_BR_FU_DEFAULT,
  parameter int unsigned BRQ_DEPTH = BRQ_DEPTH_DEFAULT
) (
  input logic                  clock,
  input logic                  reset,
  branch_resolve_queue_if.slave brq
);

  localparam int unsigned CW = $clog2(BRQ_DEPTH + 1);
  localparam int unsigned IW = (BRQ_DEPTH > 1) ? $clog2(BRQ_DEPTH) : 1;

  BRQ_SLOT       slots_q [BRQ_DEPTH];
  BRQ_SLOT       slots_d [BRQ_DEPTH];
  BRQ_SLOT       kept    [BRQ_DEPTH];
  BRQ_SLOT       arr_raw [NUM_BR_FU];
  BRQ_SLOT       arr     [NUM_BR_FU];
  logic [CW-1:0] count_q, count_d;
  logic          stall_q;
  logic          overflow_q;
  logic          dropped;
  logic [IW-1:0] sel;
  B_MASK         res_bit;
  logic          res_mis;

  always_comb begin
    sel = '0;
`ifdef BRQ_MISPRED_PRIORITY_EN
    // Scan high to low so the lowest-index mispredict wins.
    for (int i = int'(BRQ_DEPTH) - 1; i >= 0; i--) begin
      if (slots_q[i].valid && slots_q[i].entry.pkt.bm_mispred) sel = IW'(i);
    end
`endif
  end

  assign res_bit = slots_q[sel].valid ? slots_q[sel].entry.pkt.bmm : '0;
  assign res_mis = slots_q[sel].valid & slots_q[sel].entry.pkt.bm_mispred;

  always_comb begin
    for (int i = 0; i < int'(BRQ_DEPTH); i++) begin
      kept[i] = brq_resolve(slots_q[i], res_bit, res_mis);
      if (IW'(i) == sel) kept[i].valid = 1'b0;
    end
  end

  // Zero-bmm arrivals carry no resolution and are dropped before they take a slot.
  always_comb begin
    for (int p = 0; p < int'(NUM_BR_FU); p++) begin
      arr_raw[p].valid = brq.br_valid[p] && (brq.br_in[p].pkt.bmm != '0);
      arr_raw[p].entry = brq.br_in[p];
      arr[p]           = brq_resolve(arr_raw[p], res_bit, res_mis);
    end
  end

  branch_resolve_queue_brq_compact #(
    .NUM_BR_FU (NUM_BR_FU),
    .BRQ_DEPTH (BRQ_DEPTH)
  ) u_brq_compact (
    .kept       (kept),
    .arrivals   (arr),
    .slots_next (slots_d),
    .count_next (count_d),
    .dropped    (dropped)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      slots_q    <= '{default: '0};
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      slots_q    <= slots_d;
      count_q    <= count_d;
      stall_q    <= (32'(count_d) + NUM_BR_FU) > BRQ_DEPTH;
      overflow_q <= overflow_q | dropped;
    end
  end

  assign brq.branch_completing = slots_q[sel].valid ? slots_q[sel].entry.pkt : '0;
  assign brq.brq_stall         = stall_q;
  assign brq.brq_count         = count_q;
  assign brq.brq_overflow      = overflow_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vectors, a queue-level reference model checked
// every cycle, and literal expectations for the headline scenarios.
module tb_branch_resolve_queue;
  import branch_resolve_queue_pkg::*;

  localparam int unsigned NFU   = 2;
  localparam int unsigned DEPTH = 8;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  branch_resolve_queue_if #(.NUM_BR_FU(NFU), .BRQ_DEPTH(DEPTH)) brq_bus ();

  branch_resolve_queue #(
    .NUM_BR_FU (NFU),
    .BRQ_DEPTH (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .brq   (brq_bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of pending resolutions.
  BRQ_ENTRY m_q[$];
  logic     m_ovf   = 1'b0;
  logic     m_stall = 1'b0;

  function automatic int model_sel();
    int s;
    s = 0;
`ifdef BRQ_MISPRED_PRIORITY_EN
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].pkt.bm_mispred) s = i;
    end
`endif
    return s;
  endfunction

  function automatic logic killed(input BRQ_ENTRY e, input B_MASK rb, input logic rm);
    return rm && ((e.b_m & rb) != '0);
  endfunction

  // Compare against the model after each edge has settled, then advance it with the inputs
  // that the next edge will sample.
  initial begin
    BRQ_ENTRY         nq[$];
    BRQ_ENTRY         e;
    B_MASK            rb;
    logic             rm;
    int               s;
    BRANCH_REG_PACKET exp_bc;
    forever begin
      @(negedge clock);
      exp_bc = (m_q.size() > 0) ? m_q[model_sel()].pkt : '0;
      check("model_completing", 64'(brq_bus.branch_completing), 64'(exp_bc));
      check("model_count", 64'(brq_bus.brq_count), 64'(m_q.size()));
      check("model_stall", 64'(brq_bus.brq_stall), 64'(m_stall));
      check("model_overflow", 64'(brq_bus.brq_overflow), 64'(m_ovf));
      if (reset) begin
        m_q.delete();
        m_ovf   = 1'b0;
        m_stall = 1'b0;
      end else begin
        rb = '0;
        rm = 1'b0;
        if (m_q.size() > 0) begin
          s  = model_sel();
          rb = m_q[s].pkt.bmm;
          rm = m_q[s].pkt.bm_mispred;
          m_q.delete(s);
        end
        nq.delete();
        foreach (m_q[i]) begin
          if (!killed(m_q[i], rb, rm)) begin
            e     = m_q[i];
            e.b_m = e.b_m & ~rb;
            nq.push_back(e);
          end
        end
        for (int p = 0; p < int'(NFU); p++) begin
          e = brq_bus.br_in[p];
          if (brq_bus.br_valid[p] && e.pkt.bmm != '0 && !killed(e, rb, rm)) begin
            e.b_m = e.b_m & ~rb;
            if (nq.size() < int'(DEPTH)) nq.push_back(e);
            else m_ovf = 1'b1;
          end
        end
        m_q     = nq;
        m_stall = (int'(DEPTH) - m_q.size()) < int'(NFU);
      end
    end
  end

  function automatic BRQ_ENTRY mk(input B_MASK bmm, input logic mis, input B_MASK bm,
                                  input logic [31:0] tgt);
    BRQ_ENTRY e;
    e.pkt.bmm        = bmm;
    e.pkt.bm_mispred = mis;
    e.pkt.target     = tgt;
    e.b_m            = bm;
    return e;
  endfunction

  task automatic drive(input logic [1:0] v, input BRQ_ENTRY e0, input BRQ_ENTRY e1);
    brq_bus.br_valid = v;
    brq_bus.br_in[0] = e0;
    brq_bus.br_in[1] = e1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    B_MASK first;
    B_MASK second;
`ifdef BRQ_MISPRED_PRIORITY_EN
    first  = 4'b1000;
    second = 4'b0100;
`else
    first  = 4'b0100;
    second = 4'b1000;
`endif
    reset = 1'b1;
    drive(2'b00, '0, '0);
    repeat (2) tick();
    check("reset_completing", 64'(brq_bus.branch_completing), 64'd0);
    check("reset_count", 64'(brq_bus.brq_count), 64'd0);
    check("reset_stall", 64'(brq_bus.brq_stall), 64'd0);
    check("reset_overflow", 64'(brq_bus.brq_overflow), 64'd0);
    reset = 1'b0;
    tick();

    // Single arrival.
    drive(2'b01, mk(4'b0001, 1'b0, 4'b0000, 32'hA000_0001), '0);
    tick();
    drive(2'b00, '0, '0);
    check("single_bmm", 64'(brq_bus.branch_completing.bmm), 64'b0001);
    check("single_target", 64'(brq_bus.branch_completing.target), 64'hA000_0001);
    check("single_count1", 64'(brq_bus.brq_count), 64'd1);
    tick();
    check("single_idle", 64'(brq_bus.branch_completing), 64'd0);
    check("single_count0", 64'(brq_bus.brq_count), 64'd0);

    // Dual arrival, emitted in port order.
    drive(2'b11, mk(4'b0001, 1'b0, 4'b0000, 32'hB000_0000),
          mk(4'b0010, 1'b0, 4'b0000, 32'hB000_0001));
    tick();
    drive(2'b00, '0, '0);
    check("dual_first", 64'(brq_bus.branch_completing.bmm), 64'b0001);
    check("dual_count", 64'(brq_bus.brq_count), 64'd2);
    tick();
    check("dual_second", 64'(brq_bus.branch_completing.bmm), 64'b0010);
    tick();
    check("dual_idle", 64'(brq_bus.branch_completing.bmm), 64'd0);

    // Mispredict squashes its dependent.
    drive(2'b11, mk(4'b0001, 1'b1, 4'b0000, 32'hC000_0000),
          mk(4'b0010, 1'b0, 4'b0001, 32'hC000_0001));
    tick();
    drive(2'b00, '0, '0);
    check("squash_emit_bmm", 64'(brq_bus.branch_completing.bmm), 64'b0001);
    check("squash_emit_mis", 64'(brq_bus.branch_completing.bm_mispred), 64'd1);
    tick();
    check("squash_gone", 64'(brq_bus.branch_completing), 64'd0);
    check("squash_count", 64'(brq_bus.brq_count), 64'd0);

    // Correct resolve clears the bit and the dependent still emits.
    drive(2'b11, mk(4'b0001, 1'b0, 4'b0000, 32'hD000_0000),
          mk(4'b0100, 1'b0, 4'b0011, 32'hD000_0001));
    tick();
    drive(2'b00, '0, '0);
    check("correct_first", 64'(brq_bus.branch_completing.bmm), 64'b0001);
    tick();
    check("correct_second", 64'(brq_bus.branch_completing.bmm), 64'b0100);
    check("correct_count", 64'(brq_bus.brq_count), 64'd1);
    tick();

    // Ordering of a correct entry ahead of an independent mispredict.
    drive(2'b11, mk(4'b0100, 1'b0, 4'b0000, 32'hE000_0000),
          mk(4'b1000, 1'b1, 4'b0000, 32'hE000_0001));
    tick();
    drive(2'b00, '0, '0);
    check("prio_first", 64'(brq_bus.branch_completing.bmm), 64'(first));
    tick();
    check("prio_second", 64'(brq_bus.branch_completing.bmm), 64'(second));
    tick();
    check("prio_idle", 64'(brq_bus.brq_count), 64'd0);

    // Fill: two arrivals per cycle against one emit per cycle, ignoring stall.
    for (int d = 1; d <= 8; d++) begin
      drive(2'b11, mk(4'b0001, 1'b0, 4'b0000, 32'hF000_0000 + 32'(2 * d)),
            mk(4'b0010, 1'b0, 4'b0000, 32'hF000_0001 + 32'(2 * d)));
      tick();
      check("full_count", 64'(brq_bus.brq_count), 64'((d + 1 > 8) ? 8 : d + 1));
      check("full_stall", 64'(brq_bus.brq_stall), 64'(d + 1 >= 7));
      check("full_overflow", 64'(brq_bus.brq_overflow), 64'(d >= 8));
    end
    drive(2'b00, '0, '0);
    tick();
    check("drain_count7", 64'(brq_bus.brq_count), 64'd7);
    check("drain_stall7", 64'(brq_bus.brq_stall), 64'd1);
    tick();
    check("drain_stall6", 64'(brq_bus.brq_stall), 64'd0);
    check("drain_sticky", 64'(brq_bus.brq_overflow), 64'd1);
    repeat (6) tick();
    check("drain_empty", 64'(brq_bus.brq_count), 64'd0);

    // Zero-bmm arrival is discarded.
    drive(2'b01, mk(4'b0000, 1'b0, 4'b0000, 32'h1234_5678), '0);
    tick();
    drive(2'b00, '0, '0);
    check("zero_bmm_count", 64'(brq_bus.brq_count), 64'd0);

    // Reset mid-operation drops everything at that edge.
    drive(2'b11, mk(4'b0001, 1'b0, 4'b0000, 32'h7000_0000),
          mk(4'b0010, 1'b0, 4'b0000, 32'h7000_0001));
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midreset_count", 64'(brq_bus.brq_count), 64'd0);
    check("midreset_completing", 64'(brq_bus.branch_completing), 64'd0);
    check("midreset_overflow", 64'(brq_bus.brq_overflow), 64'd0);
    check("midreset_stall", 64'(brq_bus.brq_stall), 64'd0);
    drive(2'b00, '0, '0);
    reset = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Buffers branch resolutions from the branch functional units and delivers exactly one resolution per cycle to the branch stack's `branch_completing` input. Sits between the complete stage and the branch stack. Queued entries are squashed or have their masks updated as older branches resolve, so the branch stack never sees a resolution for a squashed branch. Without this block, two branch units completing in the same cycle would collide on the single-entry branch stack port.

## Interface
Parameters:
- `NUM_BR_FU`, default 2: branch results accepted per cycle.
- `BRQ_DEPTH`, default 8: queue entries; must be ≥ `NUM_BR_FU`.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `br_valid`  in  `NUM_BR_FU`  per-port result valid.
- `br_in`  in  `BRQ_ENTRY[NUM_BR_FU]`  resolution plus the branch's own dependency mask `b_m`.
- `branch_completing`  out  `BRANCH_REG_PACKET`  to branch stack; all-zero when idle (`bmm == 0` means no-op).
- `brq_stall`  out  1  registered; tells the complete stage not to present results next cycle.
- `brq_count`  out  `$clog2(BRQ_DEPTH+1)`  occupied entries.
- `brq_overflow`  out  1  sticky; set if an arrival was dropped for lack of space.

## Operation
- Storage is a compacting array. Index 0 holds the oldest entry. Each entry is `{valid, BRQ_ENTRY}`.
- **Emit:** `branch_completing` is taken from the selected entry, which is index 0 by default. Output is driven from registered state only.
- The emitted entry defines this cycle's resolution:
  - `res_bit` = its `bmm`.
  - `res_mis` = its `bm_mispred`.
- **Next-state sequence** (one cycle):
  1. Remove the emitted entry.
  2. If `res_mis`, invalidate every remaining entry whose `b_m & res_bit` is nonzero. Otherwise clear `res_bit` from every remaining entry's `b_m`.
  3. Apply the same squash/clear rule to this cycle's arrivals.
  4. Compact the survivors toward index 0, preserving order.
  5. Append surviving arrivals in ascending port order.
- **Capacity:** if an arrival finds no free slot after compaction, drop it and set `brq_overflow`.
- **Stall:** `brq_stall` next cycle = (free entries after this cycle's update < `NUM_BR_FU`).
- Arrivals while `brq_stall` is high are a protocol violation. They are accepted if space exists; otherwise the capacity rule applies.
- An entry whose `bmm` is zero is discarded on arrival.

## Timing
- Latency: a result arriving at cycle t is emitted at t+1 at the earliest. There is no combinational bypass.
- Throughput: one resolution per cycle.
- Squash takes effect in the same cycle as the emit. An entry dependent on a mispredict emitted at cycle t never appears on the output at t+1 or later.
- Reset values:
  - `branch_completing` = 0
  - `brq_stall` = 0
  - `brq_count` = 0
  - `brq_overflow` = 0
  - all entries invalid.
- Reset asserted mid-operation discards all queued entries in that same edge.
- Empty queue: output is zero. `brq_count` is updated at the same edge as the entries.

## Configuration
Macro: `BRQ_MISPRED_PRIORITY_EN`.
- **Defined:** the selected entry is the lowest-index valid entry with `bm_mispred == 1`. If there is none, index 0 is selected. Mispredict recovery starts earlier, and correct-path entries queued ahead of it keep their order.
- **Undefined:** strict FIFO; index 0 is always selected.
- In both modes, squash/clear is driven by the selected entry.

## Structure
- Shared package additions:
  - `BRQ_ENTRY` typedef (`BRANCH_REG_PACKET pkt; B_MASK b_m`).
  - `NUM_BR_FU` and `BRQ_DEPTH` defines.
- One natural sub-module, `brq_compact`: combinational order-preserving compaction of the valid vector plus arrival append. Its outputs are the next-state entries and the count.

## Test plan
- **Single arrival:** `br_valid=01`, `bmm=0001`, correct, at cycle 5 → `branch_completing.bmm=0001` at cycle 6; all-zero at cycle 7; `brq_count` 1 then 0.
- **Dual arrival:** port0 `bmm=0001`, port1 `bmm=0010`, same cycle → emitted at t+1 and t+2 in that order.
- **Mispredict squash:** queue holds A (`bmm=0001`, mispred) and B (`bmm=0010`, `b_m=0001`) → A emitted; B never emitted; `brq_count=0` afterward.
- **Correct resolve:** A (`bmm=0001`, correct), B (`b_m=0011`) → after A emits, B's `b_m=0010`; B emits next cycle.
- **Full:** with `BRQ_DEPTH=8`, `NUM_BR_FU=2`, fill to 7 → `brq_stall=1` the next cycle; forcing 2 more arrivals keeps 8 entries and sets `brq_overflow=1`.
- **Priority:** with `BRQ_MISPRED_PRIORITY_EN`, queue holds C (correct, `bmm=0100`) then D (mispred, `bmm=1000`, `b_m=0000`) → D emitted first, then C. Without the macro, the order is C then D.
